fir_ctrl: RTL and testbench

Control and arbitration front-end for the FIR engine. It terminates the AXI-Lite configuration port and holds the ap_ctrl and data_length registers. It sequences one FIR run from ap_start to ap_done, and arbitrates the single-port tap BRAM between AXI-Lite accesses and the engine's coefficient fetches. The block sits between the AXI-Lite master and the FIR MAC datapath; the datapath never drives the tap BRAM directly.

---
 rtl/fir_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fir_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl.sv
// AXI-Lite register front-end and run sequencer for the FIR engine; also arbitrates
// the single-port tap BRAM between the engine (highest), AXI writes and AXI reads.
module fir_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   awready,
  output logic                   wready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arready,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   rready,
  output logic                   eng_start,
  input  logic                   eng_done,
  input  logic                   eng_tap_req,
  input  logic [3:0]             eng_tap_idx,
  output logic                   eng_tap_gnt,
  output logic                   eng_tap_vld,
  output logic [pDATA_WIDTH-1:0] eng_tap_data,
  output logic [pDATA_WIDTH-1:0] data_length,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [pADDR_WIDTH-1:0] A_CTRL    = pADDR_WIDTH'(32'h00);
  localparam logic [pADDR_WIDTH-1:0] A_LEN     = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] A_TAP     = pADDR_WIDTH'(32'h20);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_END = pADDR_WIDTH'(32'h20 + 4 * Tape_Num);

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= A_TAP) && (a < A_TAP_END) && (a[1:0] == 2'b00);
  endfunction

  logic [0:0]             r_state;
  logic                   r_ap_done;
  logic                   r_alive;
  logic                   r_wr_pend;
  logic                   r_eng_start;
  logic                   r_eng_vld;
  logic                   r_rvalid;
  logic                   r_rd_phase;
  logic                   r_rd_tap;
  logic                   r_rd_ctrl;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic [pDATA_WIDTH-1:0] r_data_length;

  logic                   w_eng;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_idle;
  logic                   w_aw_tap;
  logic                   w_ar_tap;
  logic [pDATA_WIDTH-1:0] w_ap_ctrl;
  logic [pDATA_WIDTH-1:0] w_rd_reg;
  logic [pDATA_WIDTH-1:0] w_rdata;

  // r_alive keeps every combinational grant low while reset is (or was just) asserted.
  assign w_eng    = r_alive && eng_tap_req;
  assign w_wr_acc = r_alive && r_wr_pend && awvalid && wvalid && !eng_tap_req;
  assign w_rd_acc = r_alive && arvalid && !r_rvalid && !eng_tap_req && !r_wr_pend &&
                    !(awvalid && wvalid);
  assign w_idle   = (r_state == S_IDLE);
  assign w_aw_tap = is_tap(awaddr);
  assign w_ar_tap = is_tap(araddr);

  // ap_idle is only reported once a finished run's done flag has been collected.
  assign w_ap_ctrl = pDATA_WIDTH'({w_idle && !r_ap_done, r_ap_done, r_state == S_RUN});

  always_comb begin
    w_rd_reg = '0;
    if (araddr == A_CTRL)     w_rd_reg = w_ap_ctrl;
    else if (araddr == A_LEN) w_rd_reg = r_data_length;
  end

  // Tap data arrives from the BRAM one cycle after the read was accepted, then is held.
  assign w_rdata = (r_rd_phase && r_rd_tap) ? tap_Do : r_rdata;

  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (w_eng) begin
      tap_EN = 1'b1;
      tap_A  = pADDR_WIDTH'({eng_tap_idx, 2'b00});
    end else if (w_wr_acc && w_aw_tap && w_idle) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = awaddr - A_TAP;
      tap_Di = wdata;
    end else if (w_rd_acc && w_ar_tap) begin
      tap_EN = 1'b1;
      tap_A  = araddr - A_TAP;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state       <= S_IDLE;
      r_ap_done     <= 1'b0;
      r_alive       <= 1'b0;
      r_wr_pend     <= 1'b0;
      r_eng_start   <= 1'b0;
      r_eng_vld     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rd_phase    <= 1'b0;
      r_rd_tap      <= 1'b0;
      r_rd_ctrl     <= 1'b0;
      r_rdata       <= '0;
      r_data_length <= '0;
    end else begin
      r_alive     <= 1'b1;
      r_wr_pend   <= r_alive && awvalid && wvalid && !w_wr_acc;
      r_eng_start <= 1'b0;
      r_eng_vld   <= w_eng;
      r_rd_phase  <= w_rd_acc;

      // Clear only a done flag the master actually saw; a later set below wins.
      if (r_rvalid && rready && r_rd_ctrl && w_rdata[1]) r_ap_done <= 1'b0;

      if (r_state == S_RUN) begin
        if (eng_done) begin
          r_state   <= S_IDLE;
          r_ap_done <= 1'b1;
        end
      end else if (w_wr_acc && awaddr == A_CTRL && wdata[0]) begin
        r_state     <= S_RUN;
        r_ap_done   <= 1'b0;
        r_eng_start <= 1'b1;
      end

      if (w_wr_acc && w_idle && awaddr == A_LEN) r_data_length <= wdata;

      if (w_rd_acc) begin
        r_rvalid  <= 1'b1;
        r_rd_tap  <= w_ar_tap;
        r_rd_ctrl <= (araddr == A_CTRL);
        r_rdata   <= w_rd_reg;
      end else begin
        if (r_rd_phase)          r_rdata  <= w_rdata;
        if (r_rvalid && rready)  r_rvalid <= 1'b0;
      end
    end
  end

  assign awready      = w_wr_acc;
  assign wready       = w_wr_acc;
  assign arready      = w_rd_acc;
  assign rvalid       = r_rvalid;
  assign rdata        = w_rdata;
  assign eng_start    = r_eng_start;
  assign eng_tap_gnt  = w_eng;
  assign eng_tap_vld  = r_eng_vld;
  assign eng_tap_data = r_eng_vld ? tap_Do : '0;
  assign data_length  = r_data_length;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: behavioural tap BRAM, AXI-Lite tasks, engine stimulus.
module tb_fir_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic        awready, wready, arready, rvalid;
  logic [31:0] rdata;
  logic        eng_start, eng_done = 1'b0, eng_tap_req = 1'b0;
  logic [3:0]  eng_tap_idx = '0;
  logic        eng_tap_gnt, eng_tap_vld;
  logic [31:0] eng_tap_data, data_length;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do = '0;

  logic [31:0] mem [0:63];
  logic signed [31:0] taps [0:10] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  last_we;
  logic        last_aw_req, last_ar_req;
  logic [31:0] rd, rd2;

  always #5 axis_clk = ~axis_clk;

  fir_ctrl dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata),
    .awready(awready), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready),
    .eng_start(eng_start), .eng_done(eng_done),
    .eng_tap_req(eng_tap_req), .eng_tap_idx(eng_tap_idx),
    .eng_tap_gnt(eng_tap_gnt), .eng_tap_vld(eng_tap_vld), .eng_tap_data(eng_tap_data),
    .data_length(data_length),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do)
  );

  initial for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 + 32'(i);

  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[7:2]] <= tap_Di;
      tap_Do <= mem[tap_A[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data);
    int n = 0;
    @(posedge axis_clk); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data;
    @(negedge axis_clk);
    while (!(awready && wready) && n < 100) begin @(negedge axis_clk); n++; end
    chk("aw_handshake", 32'(awready & wready), 32'd1);
    last_we = tap_WE;
    last_aw_req = eng_tap_req;
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, input int hold, output logic [31:0] data);
    int n = 0;
    @(posedge axis_clk); #1;
    arvalid = 1'b1; araddr = addr; rready = (hold == 0);
    @(negedge axis_clk);
    while (!arready && n < 100) begin @(negedge axis_clk); n++; end
    chk("ar_handshake", 32'(arready), 32'd1);
    last_ar_req = eng_tap_req;
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    @(negedge axis_clk);
    chk("rvalid_latency", 32'(rvalid), 32'd1);
    data = rdata;
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(negedge axis_clk);
        chk("rvalid_hold", 32'(rvalid), 32'd1);
        chk("rdata_hold", rdata, data);
      end
      @(posedge axis_clk); #1;
      rready = 1'b1;
      @(negedge axis_clk);
    end
    @(posedge axis_clk); #1;
    rready = 1'b0;
    @(negedge axis_clk);
    chk("rvalid_fall", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, cw, cr;

    // reset state
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_tap_en", 32'(tap_EN), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_data_length", data_length, 0);
    axis_rst_n = 1'b1;
    repeat (2) @(posedge axis_clk);

    axi_read(12'h000, 0, rd); chk("ctrl_after_rst", rd, 32'h4);
    axi_read(12'h010, 0, rd); chk("len_after_rst", rd, 32'h0);

    // tap table write and read-back
    for (int k = 0; k < 11; k++) begin
      axi_write(12'(32'h20 + 4 * k), taps[k]);
      chk("tap_we_idle", 32'(last_we), 32'hF);
    end
    for (int k = 0; k < 11; k++) begin
      axi_read(12'(32'h20 + 4 * k), 0, rd);
      chk("tap_readback", rd, taps[k]);
    end

    // unmapped address
    axi_write(12'h004, 32'h1234_5678);
    axi_read(12'h004, 0, rd); chk("unmapped_read", rd, 32'h0);

    // start a run
    axi_write(12'h010, 32'd600);
    chk("data_length", data_length, 32'd600);
    axi_write(12'h000, 32'h1);
    @(negedge axis_clk); chk("eng_start_pulse", 32'(eng_start), 1);
    @(negedge axis_clk); chk("eng_start_end", 32'(eng_start), 0);
    axi_read(12'h000, 0, rd); chk("ctrl_running", rd, 32'h1);

    // engine fetches contend with an AXI write and read
    fork
      begin
        for (int i = 0; i < 11; i++) begin
          @(posedge axis_clk); #1;
          eng_tap_req = 1'b1; eng_tap_idx = 4'(i);
          @(negedge axis_clk);
          chk("eng_gnt", 32'(eng_tap_gnt), 1);
          chk("eng_no_we", 32'(tap_WE), 0);
          if (i > 0) begin
            chk("eng_vld", 32'(eng_tap_vld), 1);
            chk("eng_data", eng_tap_data, taps[i - 1]);
          end
        end
        @(posedge axis_clk); #1;
        eng_tap_req = 1'b0;
        @(negedge axis_clk);
        chk("eng_vld_last", 32'(eng_tap_vld), 1);
        chk("eng_data_last", eng_tap_data, taps[10]);
      end
      axi_write(12'h020, 32'd99);
      axi_read(12'h034, 0, rd2);
    join
    chk("run_wr_waits_eng", 32'(last_aw_req), 0);
    chk("run_wr_no_we", 32'(last_we), 0);
    chk("run_rd_waits_eng", 32'(last_ar_req), 0);
    chk("run_rd_value", rd2, 32'd63);

    axi_write(12'h010, 32'd5);
    chk("len_locked_in_run", data_length, 32'd600);
    axi_write(12'h000, 32'h1);
    @(negedge axis_clk); chk("no_restart_in_run", 32'(eng_start), 0);
    axi_read(12'h020, 0, rd); chk("tap0_unchanged", rd, 32'h0);

    // finish the run
    @(posedge axis_clk); #1; eng_done = 1'b1;
    @(posedge axis_clk); #1; eng_done = 1'b0;
    axi_read(12'h000, 0, rd); chk("ctrl_done", rd, 32'h2);
    axi_read(12'h000, 0, rd); chk("ctrl_done_cleared", rd, 32'h4);

    // simultaneous write and read of tap 3, read held 5 cycles
    @(posedge axis_clk); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h02C; wdata = 32'd77;
    arvalid = 1'b1; araddr = 12'h02C; rready = 1'b0;
    cyc = 0; cw = -1; cr = -1;
    while (cyc < 20) begin
      @(negedge axis_clk);
      if (awready && cw < 0) cw = cyc;
      if (arready && cr < 0) cr = cyc;
      @(posedge axis_clk); #1;
      if (cw >= 0) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (cr >= 0) begin arvalid = 1'b0; break; end
      cyc++;
    end
    chk("sim_wr_seen", 32'(cw >= 0), 1);
    chk("sim_wr_first", 32'(cr > cw), 1);
    @(negedge axis_clk);
    chk("sim_rvalid", 32'(rvalid), 1);
    chk("sim_rdata", rdata, 32'd77);
    for (int i = 1; i < 5; i++) begin
      @(negedge axis_clk);
      chk("sim_rvalid_hold", 32'(rvalid), 1);
      chk("sim_rdata_hold", rdata, 32'd77);
    end
    @(posedge axis_clk); #1; rready = 1'b1;
    @(posedge axis_clk); #1; rready = 1'b0;
    @(negedge axis_clk); chk("sim_rvalid_fall", 32'(rvalid), 0);

    // asynchronous reset in the middle of a run
    axi_write(12'h010, 32'd600);
    axi_write(12'h000, 32'h1);
    @(posedge axis_clk); #1; eng_tap_req = 1'b1; eng_tap_idx = 4'd3;
    @(posedge axis_clk); #2;
    axis_rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(eng_tap_gnt), 0);
    chk("mid_rst_vld", 32'(eng_tap_vld), 0);
    chk("mid_rst_tap_en", 32'(tap_EN), 0);
    chk("mid_rst_eng_data", eng_tap_data, 0);
    chk("mid_rst_len", data_length, 0);
    eng_tap_req = 1'b0;
    @(posedge axis_clk); #3;
    axis_rst_n = 1'b1;
    axi_read(12'h000, 0, rd); chk("ctrl_after_mid_rst", rd, 32'h4);
    axi_read(12'h02C, 0, rd); chk("bram_kept", rd, 32'd77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
